// File: rtl/counter.sv
// Modulo-cnt_max event counter with a combinational terminal-count strobe.
// Note: rst_n is an active-high synchronous reset; the name is kept so existing instantiations still connect.
module counter #(
    parameter int unsigned cnt_max = 32,
    parameter int unsigned CNT_W   = (cnt_max > 1) ? $clog2(cnt_max) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_add,
    output logic             cnt_end,
    output logic [CNT_W-1:0] cnt
);

    // The last count value is truncated to CNT_W bits. This lets cnt_max = 2^16 wrap at 16'hFFFF.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cnt_max - 1);

    logic at_last;

    always_comb begin
        at_last = (cnt == CNT_LAST);
        cnt_end = cnt_add & ~rst_n & at_last;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= '0;
        end else if (cnt_add) begin
            if (at_last) cnt <= '0;
            else         cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter with cnt_max = 32, 10 and 1, driven from shared stimulus.
// An event-count model checks every cycle, and literal expectations check the directed scenarios.
module tb_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       add = 1'b0;
    logic       end32, end10, end1;
    logic [4:0] cnt32;
    logic [3:0] cnt10;
    logic [0:0] cnt1;

    int tests  = 0;
    int failed = 0;
    int ev32 = 0, ev10 = 0, ev1 = 0;
    int max10 = 0;

    counter #(.cnt_max(32)) dut32 (.clk(clk), .rst_n(rst), .cnt_add(add), .cnt_end(end32), .cnt(cnt32));
    counter #(.cnt_max(10)) dut10 (.clk(clk), .rst_n(rst), .cnt_add(add), .cnt_end(end10), .cnt(cnt10));
    counter #(.cnt_max(1))  dut1  (.clk(clk), .rst_n(rst), .cnt_add(add), .cnt_end(end1),  .cnt(cnt1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The model counts accepted events since the last reset.
    always @(posedge clk) begin
        if (rst) begin
            ev32 <= 0; ev10 <= 0; ev1 <= 0;
        end else if (add) begin
            ev32 <= ev32 + 1; ev10 <= ev10 + 1; ev1 <= ev1 + 1;
        end
    end

    always @(negedge clk) begin
        chk("m32_cnt", int'(cnt32), ev32 % 32);
        chk("m32_end", int'(end32), int'(!rst && add && ((ev32 + 1) % 32 == 0)));
        chk("m10_cnt", int'(cnt10), ev10 % 10);
        chk("m10_end", int'(end10), int'(!rst && add && ((ev10 + 1) % 10 == 0)));
        chk("m1_cnt",  int'(cnt1), 0);
        chk("m1_end",  int'(end1), int'(!rst && add));
        if (int'(cnt10) > max10) max10 = int'(cnt10);
    end

    // Each cycle's inputs are applied just after the rising edge. The task returns at the falling edge.
    task automatic cyc(input logic r, input logic a);
        @(posedge clk);
        #1;
        rst = r;
        add = a;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n32, n10, n1;

        // Hold reset with add high. The count stays 0 and no strobe is raised.
        repeat (2) begin
            cyc(1'b1, 1'b1);
            chk("rst_cnt32", int'(cnt32), 0);
            chk("rst_end32", int'(end32), 0);
        end

        // Count continuously for 64 cycles.
        n32 = 0; n10 = 0; n1 = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 1'b1);
            if (end32) begin
                n32++;
                chk("cont_end_at31", int'(cnt32), 31);
            end
            if (end10) n10++;
            if (end1)  n1++;
        end
        chk("cont_pulses32", n32, 2);
        chk("cont_pulses10", n10, 6);
        chk("cont_pulses1",  n1, 64);
        cyc(1'b1, 1'b0);
        chk("after64_cnt32", int'(cnt32), 0);
        chk("after64_cnt10", int'(cnt10), 4);

        // Toggle add on alternate cycles for 128 cycles, which gives 64 events.
        n32 = 0;
        for (int i = 0; i < 128; i++) begin
            cyc(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
            if (end32) n32++;
        end
        chk("gap_pulses32", n32, 2);

        // Reset in the middle of a period.
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("mid_cnt20", int'(cnt32), 20);
        cyc(1'b1, 1'b1);
        chk("mid_rst_end", int'(end32), 0);
        cyc(1'b0, 1'b0);
        chk("mid_rst_cnt", int'(cnt32), 0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("first_event", int'(cnt32), 1);
        n32 = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b1);
            if (end32) n32++;
        end
        chk("no_early_pulse", n32, 0);

        // Hold at the terminal count, then take one event.
        cyc(1'b0, 1'b0);
        chk("hold31_cnt", int'(cnt32), 31);
        chk("hold31_end", int'(end32), 0);
        cyc(1'b0, 1'b0);
        chk("hold31_cnt2", int'(cnt32), 31);
        cyc(1'b0, 1'b1);
        chk("term_end", int'(end32), 1);
        cyc(1'b0, 1'b0);
        chk("wrap_cnt", int'(cnt32), 0);

        // Assert reset while at the terminal count. Reset masks the strobe.
        for (int i = 0; i < 31; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("rst_at31_cnt", int'(cnt32), 31);
        chk("rst_at31_end", int'(end32), 0);
        cyc(1'b0, 1'b0);
        chk("rst_at31_clr", int'(cnt32), 0);

        // With cnt_max = 1, the strobe follows add.
        cyc(1'b0, 1'b1);
        chk("m1_p1_end", int'(end1), 1);
        chk("m1_p1_cnt", int'(cnt1), 0);
        cyc(1'b0, 1'b0);
        chk("m1_p2_end", int'(end1), 0);
        cyc(1'b0, 1'b1);
        chk("m1_p3_end", int'(end1), 1);
        chk("m1_p3_cnt", int'(cnt1), 0);
        cyc(1'b0, 1'b0);

        chk("m10_max_seen", max10, 9);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
